// File: rtl/divider_seq_ctrl_if.sv
// Bus-side handshake between the divider sequencer and its requester.
// The requester drives start/divisor_zero/abort and observes status and progress.
interface divider_seq_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             divisor_zero;
  logic             abort;
  logic             busy;
  logic             done;
  logic             dbz_err;
  logic [CNT_W-1:0] iter_cnt;

  modport master (
    output start, divisor_zero, abort,
    input  busy, done, dbz_err, iter_cnt
  );

  modport slave (
    input  start, divisor_zero, abort,
    output busy, done, dbz_err, iter_cnt
  );
endinterface

// File: rtl/divider_seq_ctrl.sv
// Sequencer for a restoring divider: drives load/clear/shift/subtract strobes
// over WIDTH iterations and reports busy/done/divide-by-zero on the bus side.
module divider_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  divider_seq_ctrl_if.slave   bus,
  input  logic                diff_neg,
  output logic                load_q,
  output logic                load_m,
  output logic                clr_a,
  output logic                shift_aq,
  output logic                load_a,
  output logic                set_q0
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
  logic             dbz_err_q, dbz_err_d;
  logic             load_grp_q, load_grp_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next state, counter and error flag; strobes are derived from the next
  // state so they are registered and never see start/divisor_zero directly.
  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    dbz_err_d  = dbz_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.divisor_zero) begin
          state_d   = S_LOAD;
          dbz_err_d = 1'b0;
        end else if (bus.start) begin
          state_d   = S_ERR;
          dbz_err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          state_d    = S_SHIFT;
          iter_cnt_d = {CNT_W{1'b0}};
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SUB;
        end
      end
      S_SUB: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          iter_cnt_d = iter_cnt_q + CNT_W'(1);
          if (iter_cnt_q == LAST_ITER) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    load_grp_d = (state_d == S_LOAD);
    shift_d    = (state_d == S_SHIFT);
    busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_SUB);
    done_d     = (state_d == S_DONE) || (state_d == S_ERR);
  end

  // State, counter, error flag and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      iter_cnt_q <= {CNT_W{1'b0}};
      dbz_err_q  <= 1'b0;
      load_grp_q <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      dbz_err_q  <= dbz_err_d;
      load_grp_q <= load_grp_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign load_q   = load_grp_q;
  assign load_m   = load_grp_q;
  assign clr_a    = load_grp_q;
  assign shift_aq = shift_q;
  // Restore is implicit: a negative difference simply suppresses both writes.
  assign load_a   = (state_q == S_SUB) & ~diff_neg;
  assign set_q0   = (state_q == S_SUB) & ~diff_neg;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dbz_err  = dbz_err_q;
  assign bus.iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Directed bench for divider_seq_ctrl with a behavioural restoring-divider
// datapath; cycle n means the half-cycle after rising edge n (edge 0 samples start).
module tb_divider_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        diff_neg;
  logic        load_q, load_m, clr_a, shift_aq, load_a, set_q0;
  logic [15:0] dividend, divisor;
  logic [16:0] a_m;
  logic [15:0] q_m, m_m;
  logic [17:0] diff;
  int          checks, errors, excl_bad;
  int          fd, nd, nb, lb, nla, nst;
  logic        dbz1;

  divider_seq_ctrl_if #(.CNT_W(5)) bus ();

  divider_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .diff_neg (diff_neg),
    .load_q   (load_q),
    .load_m   (load_m),
    .clr_a    (clr_a),
    .shift_aq (shift_aq),
    .load_a   (load_a),
    .set_q0   (set_q0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: A (17 bits), Q, M and the A-M subtractor.
  assign diff     = {1'b0, a_m} - {2'b00, m_m};
  assign diff_neg = diff[17];

  always @(posedge clk) begin
    if (load_q)   q_m <= dividend;
    if (load_m)   m_m <= divisor;
    if (clr_a)    a_m <= 17'd0;
    if (shift_aq) {a_m, q_m} <= {a_m[15:0], q_m, 1'b0};
    if (load_a)   a_m <= diff[16:0];
    if (set_q0)   q_m[0] <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts one operation at the current falling edge and observes ncyc cycles.
  task automatic run_op(input logic [15:0] dd, input logic [15:0] dv, input logic dz,
                        input int s1, input int s2, input int ab, input int ncyc,
                        output int first_done, output int n_done, output int n_busy,
                        output int last_busy, output int n_la, output int n_strb,
                        output logic dbz_c1);
    first_done = 0; n_done = 0; n_busy = 0; last_busy = 0; n_la = 0; n_strb = 0;
    dbz_c1 = 1'b0; excl_bad = 0;
    dividend = dd; divisor = dv;
    bus.divisor_zero = dz; bus.start = 1'b1; bus.abort = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (bus.busy) begin
        n_busy++;
        last_busy = c;
      end
      if (load_a) n_la++;
      if (load_q | load_m | clr_a | shift_aq | load_a | set_q0) n_strb++;
      if (c == 1) dbz_c1 = bus.dbz_err;
      if (int'(load_q | load_m | clr_a) + int'(shift_aq) + int'(load_a) > 1) excl_bad++;
      bus.start = (c == s1) || (c == s2);
      bus.abort = (c == ab);
      bus.divisor_zero = 1'b0;
    end
  endtask

  function automatic logic [13:0] all_outs();
    return {load_q, load_m, clr_a, shift_aq, load_a, set_q0,
            bus.busy, bus.done, bus.dbz_err, bus.iter_cnt};
  endfunction

  initial begin
    checks = 0; errors = 0; excl_bad = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.divisor_zero = 1'b0; bus.abort = 1'b0;
    dividend = 16'd0; divisor = 16'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(all_outs()), 32'd0);

    // 100/7 with ignored start pulses in cycles 5 and 34
    run_op(16'd100, 16'd7, 1'b0, 5, 34, 0, 36, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t1_done_cycle", 32'(fd), 32'd34);
    chk("t1_done_count", 32'(nd), 32'd1);
    chk("t1_busy_count", 32'(nb), 32'd33);
    chk("t1_busy_last", 32'(lb), 32'd33);
    chk("t1_quotient", 32'(q_m), 32'd14);
    chk("t1_remainder", 32'(a_m), 32'd2);
    chk("t1_iter_cnt", 32'(bus.iter_cnt), 32'd16);
    chk("t1_load_a_count", 32'(nla), 32'd3);
    chk("t1_mutex", 32'(excl_bad), 32'd0);

    // 0xFFFF/1: every subtraction succeeds
    run_op(16'hFFFF, 16'd1, 1'b0, 0, 0, 0, 35, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t2_done_cycle", 32'(fd), 32'd34);
    chk("t2_quotient", 32'(q_m), 32'h0000FFFF);
    chk("t2_remainder", 32'(a_m), 32'd0);
    chk("t2_load_a_count", 32'(nla), 32'd16);
    chk("t2_mutex", 32'(excl_bad), 32'd0);

    // divide by zero, then 9/3 clears the flag on acceptance
    run_op(16'd5, 16'd0, 1'b1, 0, 0, 0, 3, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t3_err_done_cycle", 32'(fd), 32'd1);
    chk("t3_err_done_count", 32'(nd), 32'd1);
    chk("t3_err_dbz_c1", 32'(dbz1), 32'd1);
    chk("t3_err_no_busy", 32'(nb), 32'd0);
    chk("t3_err_no_strobes", 32'(nst), 32'd0);
    chk("t3_err_dbz_held", 32'(bus.dbz_err), 32'd1);
    chk("t3_err_iter_held", 32'(bus.iter_cnt), 32'd16);
    run_op(16'd9, 16'd3, 1'b0, 0, 0, 0, 35, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t3_dbz_cleared", 32'(dbz1), 32'd0);
    chk("t3_done_cycle", 32'(fd), 32'd34);
    chk("t3_quotient", 32'(q_m), 32'd3);
    chk("t3_remainder", 32'(a_m), 32'd0);

    // abort in cycle 10 (SHIFT after four SUBs)
    run_op(16'd100, 16'd7, 1'b0, 0, 0, 10, 14, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t4_abort_no_done", 32'(nd), 32'd0);
    chk("t4_abort_busy_last", 32'(lb), 32'd10);
    chk("t4_abort_iter_cnt", 32'(bus.iter_cnt), 32'd4);
    run_op(16'd100, 16'd7, 1'b0, 0, 0, 0, 35, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t4_rerun_done_cycle", 32'(fd), 32'd34);
    chk("t4_rerun_busy_count", 32'(nb), 32'd33);
    chk("t4_rerun_quotient", 32'(q_m), 32'd14);
    chk("t4_rerun_remainder", 32'(a_m), 32'd2);

    // async reset in the middle of iteration 7's SUB cycle (cycle 15)
    dividend = 16'd100; divisor = 16'd7; bus.start = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("t5_busy_before_reset", 32'(bus.busy), 32'd1);
    chk("t5_iter_before_reset", 32'(bus.iter_cnt), 32'd6);
    #2 reset = 1'b1;
    #1 chk("t5_async_reset_outputs", 32'(all_outs()), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_release", 32'(all_outs()), 32'd0);
    run_op(16'd100, 16'd7, 1'b0, 0, 0, 0, 35, fd, nd, nb, lb, nla, nst, dbz1);
    chk("t5_rerun_done_cycle", 32'(fd), 32'd34);
    chk("t5_rerun_quotient", 32'(q_m), 32'd14);
    chk("t5_rerun_remainder", 32'(a_m), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_seq_ctrl.md
Name: divider_seq_ctrl

Overview:
- FSM sequencer for the restoring-divider datapath: remainder register A, quotient shift register Q, divisor register M and the A−M subtractor.
- Accepts a start request from the bus interface and drives load, clear and shift strobes for WIDTH shift/subtract iterations.
- Reports busy, done and divide-by-zero back to the bus side.
- Contains no arithmetic; it consumes only status bits returned by the datapath.

Parameters:
- WIDTH, 16, operand width; equals the number of iterations.
- CNT_W, $clog2(WIDTH+1), width of the iteration counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; returns the FSM to IDLE
- start  in  1  operation request; sampled only in IDLE
- divisor_zero  in  1  high when the divisor operand on the bus is 0; valid alongside start
- abort  in  1  synchronous cancel
- diff_neg  in  1  sign bit of the combinational subtractor result (A−M); meaningful in SUB only
- load_q  out  1  load dividend into Q
- load_m  out  1  load divisor into M
- clr_a  out  1  clear A
- shift_aq  out  1  shift A:Q left by one; Q shifts in 0, A shifts in Q MSB
- load_a  out  1  write the subtractor difference into A
- set_q0  out  1  force Q[0]=1
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- dbz_err  out  1  divide-by-zero flag
- iter_cnt  out  CNT_W  completed iterations

Behaviour:
- Reset (async): state=IDLE, iter_cnt=0, dbz_err=0; all strobes, busy and done = 0.
- States: IDLE, LOAD, SHIFT, SUB, DONE, ERR.
- IDLE:
  - start=1 and divisor_zero=0 -> LOAD; clear dbz_err at that edge.
  - start=1 and divisor_zero=1 -> ERR.
  - start=0 -> stay in IDLE.
- LOAD:
  - Outputs: load_q=load_m=clr_a=1, busy=1; iter_cnt cleared at exit edge.
  - Next state -> SHIFT.
- SHIFT:
  - Outputs: shift_aq=1, busy=1.
  - Next state -> SUB.
- SUB:
  - Outputs: busy=1; load_a=set_q0=~diff_neg (Mealy, same cycle).
  - diff_neg=1 means restore: A is left unchanged and Q[0] stays 0.
  - iter_cnt increments at exit.
  - If iter_cnt==WIDTH-1 -> DONE, else -> SHIFT.
- DONE:
  - Outputs: done=1, busy=0, no strobes.
  - Next state -> IDLE.
  - Quotient in Q and remainder in A are valid from this cycle until the next LOAD.
- ERR:
  - Outputs: done=1; dbz_err set at entry edge; no strobes.
  - Next state -> IDLE.
  - dbz_err remains high until the next accepted start or reset.
- Latency: start sampled at edge 0; LOAD in cycle 1; SHIFT in cycles 2,4,…,2W; SUB in cycles 3,…,2W+1; DONE in cycle 2W+2 (34 for W=16). ERR occurs in cycle 1.
- start asserted in any state other than IDLE (including DONE/ERR) is ignored; it is not queued.
- abort=1 in LOAD, SHIFT or SUB:
  - Next edge -> IDLE, with no done pulse.
  - Strobes in the aborting cycle still follow the current state.
  - iter_cnt holds its value.
- abort in IDLE, DONE or ERR has no effect.
- reset mid-operation: immediate IDLE; all outputs take their reset values asynchronously.
- Mutual exclusion: at most one of {load_q/load_m/clr_a group, shift_aq, load_a} is active in any cycle.
- No combinational path from start or divisor_zero to any output.

Test Plan:
- Reset, then start with dividend 100, divisor 7, using a behavioural datapath model -> busy high in cycles 1–33; done only in cycle 34; Q=14, A=2; iter_cnt=16.
- Start with dividend 0xFFFF, divisor 1 -> Q=0xFFFF, A=0; load_a asserted in all 16 SUB cycles.
- Start with divisor_zero=1 -> ERR in cycle 1 with done=1, dbz_err=1 and no strobes. Next valid start (9/3) -> dbz_err cleared at acceptance, Q=3, A=0.
- start pulsed again in cycles 5 and 34 during a 100/7 run -> ignored; exactly one done; FSM idle in cycle 35.
- abort in cycle 10 -> IDLE in cycle 11, no done, iter_cnt=4. A following start runs a full 34-cycle operation.
- Async reset asserted mid-cycle during SUB of iteration 7 -> all outputs 0 immediately; state IDLE after release; next start behaves normally.
